// File: rtl/sub_32bits_pipe_pkg.sv
// sub_32bits_pipe: shared widths for the sliced borrow-chain subtractor.
// Stage k resolves slice k; rem_bits(k) is the skew still carried after it.
package sub_pkg;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int STAGES = WIDTH / SLICE;

    function automatic int rem_bits(int k);
        return WIDTH - (k + 1) * SLICE;
    endfunction

endpackage

// File: rtl/sub_32bits_pipe_if.sv
// sub_32bits_pipe: operand/result handshake bundle.
interface sub_32bits_pipe_if;
    import sub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bo;

    modport master (
        output in_valid, a, b, bi, out_ready,
        input  in_ready, out_valid, d, bo
    );

    modport slave (
        input  in_valid, a, b, bi, out_ready,
        output in_ready, out_valid, d, bo
    );

endinterface

// File: rtl/sub_32bits_pipe_slice.sv
// sub_32bits_pipe: one combinational slice of the borrow chain.
module sub_slice
    import sub_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bi,
    output logic [SLICE-1:0] d,
    output logic             bo
);

    assign {bo, d} = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bi};

endmodule

// File: rtl/sub_32bits_pipe.sv
// sub_32bits_pipe: four-stage a - b - bi with global-enable handshake.
module sub_32bits_pipe
    import sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    sub_32bits_pipe_if.slave bus
);

    logic advance;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [SLICE-1:0]       xa;
        logic [SLICE-1:0]       xb;
        logic [SLICE-1:0]       dif;
        logic                   cin;
        logic                   cout;
        logic                   take;
        logic [(k+1)*SLICE-1:0] dn;
        logic [(k+1)*SLICE-1:0] d_r;
        logic                   br_r;
        logic                   v_r;

        sub_slice u_slice (
            .a  (xa),
            .b  (xb),
            .bi (cin),
            .d  (dif),
            .bo (cout)
        );

        if (k == 0) begin : g_src
            assign xa   = bus.a[SLICE-1:0];
            assign xb   = bus.b[SLICE-1:0];
            assign cin  = bus.bi;
            assign take = bus.in_valid;
            assign dn   = dif;
        end else begin : g_src
            assign xa   = g_st[k-1].g_sk.a_r[SLICE-1:0];
            assign xb   = g_st[k-1].g_sk.b_r[SLICE-1:0];
            assign cin  = g_st[k-1].br_r;
            assign take = g_st[k-1].v_r;
            assign dn   = {dif, g_st[k-1].d_r};
        end

        // Data only loads for a real operand, so bubbles leave it intact.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r  <= 1'b0;
                br_r <= 1'b0;
                d_r  <= '0;
            end else if (advance) begin
                v_r <= take;
                if (take) begin
                    br_r <= cout;
                    d_r  <= dn;
                end
            end
        end

        if (k < STAGES - 1) begin : g_sk
            localparam int REM = rem_bits(k);

            logic [REM-1:0] an;
            logic [REM-1:0] bn;
            logic [REM-1:0] a_r;
            logic [REM-1:0] b_r;

            if (k == 0) begin : g_nx
                assign an = bus.a[WIDTH-1:SLICE];
                assign bn = bus.b[WIDTH-1:SLICE];
            end else begin : g_nx
                assign an = g_st[k-1].g_sk.a_r[REM+SLICE-1:SLICE];
                assign bn = g_st[k-1].g_sk.b_r[REM+SLICE-1:SLICE];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance && take) begin
                    a_r <= an;
                    b_r <= bn;
                end
            end
        end
    end

    assign bus.out_valid = g_st[STAGES-1].v_r;
    assign bus.d         = g_st[STAGES-1].d_r;
    assign bus.bo        = g_st[STAGES-1].br_r;

endmodule

// File: tb/tb_sub_32bits_pipe.sv
// Bench for sub_32bits_pipe: vector table, random stream, stall,
// bubble and mid-stream reset sequences against a golden subtract.
module tb_sub_32bits_pipe;
    import sub_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] d;
        logic        bo;
    } vec_t;

    logic clk;
    logic rst_n;

    sub_32bits_pipe_if bus ();

    sub_32bits_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_out = 0;

    logic [32:0] exp_q[$];
    logic        s_ready;
    logic        s_ovalid;
    logic        s_bo;
    logic [31:0] s_d;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [32:0] golden(logic [31:0] a, logic [31:0] b,
                                           logic bi);
        return {1'b0, a} - {1'b0, b} - 33'(bi);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic bi);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.bi       = bi;
    endtask

    // Sample mid-cycle, score both handshakes, then advance one clock.
    task automatic step();
        logic [32:0] e;
        #1;
        s_ready  = bus.in_ready;
        s_ovalid = bus.out_valid;
        s_d      = bus.d;
        s_bo     = bus.bo;
        if (bus.in_valid && s_ready) begin
            exp_q.push_back(golden(bus.a, bus.b, bus.bi));
            n_acc++;
        end
        if (s_ovalid && bus.out_ready) begin
            n_out++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_out act=%h exp=none", {s_bo, s_d});
            end else begin
                total--;
                e = exp_q.pop_front();
                chk("stream", {s_bo, s_d}, e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t tab [10];
        int   nr;
        int   nov;
        int   base;
        logic [3:0]  pat;
        logic [32:0] e;

        tab[0] = '{32'h0000_0010, 32'h0000_0003, 1'b0, 32'h0000_000D, 1'b0};
        tab[1] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1};
        tab[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0};
        tab[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        tab[4] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b0};
        tab[5] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1};
        tab[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0};
        tab[7] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0};
        tab[8] = '{32'h0100_0000, 32'h0000_0001, 1'b1, 32'h00FF_FFFE, 1'b0};
        tab[9] = '{32'h1234_5678, 32'h1234_5679, 1'b0, 32'hFFFF_FFFF, 1'b1};

        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 33'(bus.out_valid), 33'd0);
        chk("rst_d", 33'(bus.d), 33'd0);
        chk("rst_bo", 33'(bus.bo), 33'd0);
        chk("rst_in_ready", 33'(bus.in_ready), 33'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single operands: exact latency and hand-derived results.
        foreach (tab[i]) begin
            drive(1'b1, tab[i].a, tab[i].b, tab[i].bi);
            step();
            for (int j = 0; j < 4; j++) begin
                drive(1'b0, $urandom(), $urandom(), j[0]);
                step();
                chk("latency", 33'(s_ovalid), 33'(j == 3));
            end
            chk("table", {s_bo, s_d}, {tab[i].bo, tab[i].d});
        end

        // Back-to-back random stream with bi toggling.
        nr  = 0;
        nov = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, pick(), pick(), i[0]);
            step();
            nr  += int'(s_ready);
            nov += int'(s_ovalid);
        end
        chk("stream_ready", 33'(nr), 33'd300);
        chk("throughput", 33'(nov), 33'd296);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (6) step();
        chk("drain", 33'(exp_q.size()), 33'd0);
        chk("count", 33'(n_out), 33'(n_acc));

        // Backpressure: hold the head for 5 cycles.
        base = n_out;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pick(), pick(), i[0]);
            step();
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pick(), pick(), i[0]);
            step();
            chk("stall_ready", 33'(s_ready), 33'd0);
            chk("stall_valid", 33'(s_ovalid), 33'd1);
            chk("stall_hold", {s_bo, s_d}, exp_q[0]);
        end
        bus.out_ready = 1'b1;
        step();
        drive(1'b1, pick(), pick(), 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (8) step();
        chk("bp_count", 33'(n_out - base), 33'd6);
        chk("bp_drain", 33'(exp_q.size()), 33'd0);

        // Bubbles are preserved, four cycles later.
        pat = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            drive(i < 4 ? pat[i[1:0]] : 1'b0, pick(), pick(), i[0]);
            step();
            chk("bubble", 33'(s_ovalid),
                33'((i >= 4 && i < 8) ? pat[2'(i - 4)] : 1'b0));
        end

        // Reset with three operands in flight and the head stalled.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pick(), pick(), 1'b1);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 33'(bus.out_valid), 33'd0);
        chk("midrst_ready", 33'(bus.in_ready), 33'd1);
        exp_q.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("flushed", 33'(s_ovalid), 33'd0);
        end
        drive(1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1);
        e = golden(32'h0000_1000, 32'h0000_2000, 1'b1);
        step();
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0);
            step();
            chk("post_rst_lat", 33'(s_ovalid), 33'(j == 3));
        end
        chk("post_rst_val", {s_bo, s_d}, e);
        chk("post_rst_const", {s_bo, s_d}, {1'b1, 32'hFFFF_EFFF});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
